rcb_spi_slave: RTL and testbench
================================

# rcb_spi_slave

SPI slave front end of the RCB FPGA. It sits directly downstream of the board SPI master. It oversamples `sclk`/`cs_n`/`mosi` in the `clk_100m` domain and decodes 56-bit frames (command, address, data). Each decoded frame becomes one register-file write strobe or one read request, and read data is shifted back on `miso`.

## Interface
Parameters:
- `CMD_WR`, 8'h01, write command code
- `CMD_RD`, 8'h02, read command code
- `TIMEOUT`, 16'd2000, `clk_100m` cycles without an `sclk` edge before a frame is aborted (only with `RCB_SPI_TIMEOUT_EN`)

Ports:
- `clk_100m`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-high reset
- `sclk`  in  1  SPI clock, mode 0, asynchronous, max 10 MHz
- `cs_n`  in  1  SPI chip select, active low, asynchronous
- `mosi`  in  1  SPI data in, MSB first
- `miso`  out  1  SPI data out, MSB first
- `wr_en`  out  1  one-cycle write strobe
- `wr_addr`  out  16  write address, valid with `wr_en`
- `wr_data`  out  32  write data, valid with `wr_en`
- `rd_req`  out  1  one-cycle read request
- `rd_addr`  out  16  read address, held from `rd_req` until the end of the frame
- `rd_data`  in  32  register-file read data, valid exactly 1 cycle after `rd_req`
- `busy`  out  1  frame in progress
- `frame_err`  out  1  one-cycle pulse on an aborted or invalid frame
- `err_cnt`  out  8  error counter, saturates at 8'hFF

## Operation
- **Synchronisation:** `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchroniser. Rise/fall of `sclk` is detected from the synchronised value and its delayed copy. `cs_n` low is detected the same way.
- **FSM states:** IDLE, CMD, ADDR, DATA, DONE.
  - IDLE→CMD when synchronised `cs_n` falls.
  - CMD→ADDR after 8 `sclk` rises.
  - ADDR→DATA after 16 rises.
  - DATA→DONE after 32 rises.
  - DONE→IDLE when `cs_n` rises.
- `mosi` is sampled on the detected `sclk` rise. A 6-bit bit counter runs 0..55.
- **Write frame** (command == `CMD_WR`): on the 56th rise, `wr_addr`/`wr_data` are loaded and `wr_en` pulses for one cycle in the same cycle.
- **Read frame** (command == `CMD_RD`):
  - On the 24th rise, `rd_addr` is loaded and `rd_req` pulses.
  - One cycle later, `rd_data` is captured into a 32-bit shift register.
  - `miso` = shift[31] is updated on each detected `sclk` fall during DATA. The first fall after ADDR presents bit 31.
- During CMD/ADDR, and for any non-read frame, `miso` = 0. In IDLE, `miso` = 0.
- **Unknown command:** the frame is clocked through with no `wr_en`/`rd_req`. `frame_err` pulses when `cs_n` rises.
- **Abort:** `cs_n` rises in any state other than DONE/IDLE → return to IDLE, no `wr_en`, `frame_err` pulse, `err_cnt`+1.
- **Extra clocks:** extra `sclk` rises in DONE are ignored.
- `err_cnt` saturates at 8'hFF. It is cleared only by `rst`.
- `busy` = 1 in every state except IDLE.

## Timing
- **Reset values:** `miso`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_req`=0, `rd_addr`=0, `busy`=0, `frame_err`=0, `err_cnt`=0, FSM=IDLE, synchroniser FFs=1 for `cs_n`/`sclk`... except `sclk` FF=0, `mosi` FF=0.
- **Edge latency:** a pin edge is seen internally 3 `clk_100m` cycles later (2 synchroniser FFs + edge register).
- **Write strobe:** `wr_en` asserts 3 cycles after the pin `sclk` rise of bit 55.
- **Read path:** `rd_req` asserts 3 cycles after the pin rise of bit 23. `rd_data` is captured 4 cycles after that rise. `miso` changes 3–4 cycles after a pin `sclk` fall. At 10 MHz this leaves at least 1 cycle of setup before the next master sample edge.
- **Reset mid-frame:** all state is cleared immediately (asynchronously). The in-flight frame is dropped without `frame_err`.
- **`cs_n` rise in the same cycle as the 56th rise:** the write completes; this is not an abort.

## Configuration
- **`RCB_SPI_TIMEOUT_EN` defined:** a 16-bit idle counter runs in CMD/ADDR/DATA. It reloads on each detected `sclk` edge. On reaching `TIMEOUT`, the FSM goes to DONE, `frame_err` pulses, `err_cnt`+1, and no `wr_en` is issued. The FSM waits in DONE for `cs_n` high.
- **Undefined:** no counter; a stalled frame stays in its state until `cs_n` rises or `rst` asserts.

## Test plan
- **Write frame:** write 01/0x0010/0xDEADBEEF at 10 MHz → a single `wr_en` with `wr_addr`=0x0010, `wr_data`=0xDEADBEEF; `err_cnt`=0.
- **Read frame:** read 02/0x0020, model returns 0x12345678 one cycle after `rd_req` → `rd_addr`=0x0020, master captures 0x12345678 on `miso`.
- **Aborted frame:** release `cs_n` after 30 bits of a write → no `wr_en`, one `frame_err`, `err_cnt`=1.
- **Unknown command:** command 0x7F → no `wr_en`/`rd_req`, `frame_err` at `cs_n` rise; also run 256 aborted frames → `err_cnt`=0xFF.
- **Reset and timeout:** assert `rst` mid-ADDR → all outputs return to reset values next cycle, then a good write succeeds. With `RCB_SPI_TIMEOUT_EN` and `TIMEOUT`=100, stop `sclk` during DATA → `frame_err` 100 cycles after the last edge, no `wr_en`.

Source files
------------

// File: rtl/rcb_spi_slave.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi in clk_100m, decodes 56-bit cmd/addr/data frames.
// Optional idle timeout is compiled in with `define RCB_SPI_TIMEOUT_EN.
module rcb_spi_slave #(
    parameter logic [7:0]  CMD_WR  = 8'h01,
    parameter logic [7:0]  CMD_RD  = 8'h02,
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        sclk_s1, sclk_s2, sclk_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        mosi_s1, mosi_s2;
    logic        sclk_rise, sclk_fall, cs_fall, cs_high;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_q;
    logic [7:0]  cmd_q;
    logic [15:0] addr_q;
    logic [31:0] miso_shift;
    logic        to_q;
    logic        timeout_hit;
    logic        do_shift, ld_cmd, ld_addr, do_wr, do_rd, err_pulse, set_to;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_d   <= 1'b1;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            cs_s1   <= cs_n;    cs_s2   <= cs_s1;   cs_d   <= cs_s2;
            mosi_s1 <= mosi;    mosi_s2 <= mosi_s1;
        end
    end

    // mosi passes through the same depth as sclk, so mosi_s2 is aligned with sclk_rise.
    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign cs_high   = cs_s2;

`ifdef RCB_SPI_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        active;
    assign active = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (!active || sclk_rise || sclk_fall)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 16'd1;
    end
    assign timeout_hit = active && !(sclk_rise || sclk_fall) && (idle_cnt == TIMEOUT - 16'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        do_shift  = 1'b0;
        ld_cmd    = 1'b0;
        ld_addr   = 1'b0;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        err_pulse = 1'b0;
        set_to    = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD, ADDR: begin
                if (cs_high) begin
                    state_d   = IDLE;
                    err_pulse = 1'b1;
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                    if (state_q == CMD && bit_cnt == 6'd7) begin
                        ld_cmd  = 1'b1;
                        state_d = ADDR;
                    end else if (state_q == ADDR && bit_cnt == 6'd23) begin
                        ld_addr = 1'b1;
                        do_rd   = (cmd_q == CMD_RD);
                        state_d = DATA;
                    end
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    err_pulse = 1'b1;
                    set_to    = 1'b1;
                end
            end
            DATA: begin
                // The final rise wins over a simultaneous cs_n release.
                if (sclk_rise && bit_cnt == 6'd55) begin
                    do_shift = 1'b1;
                    do_wr    = (cmd_q == CMD_WR);
                    state_d  = DONE;
                end else if (cs_high) begin
                    state_d   = IDLE;
                    err_pulse = 1'b1;
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    err_pulse = 1'b1;
                    set_to    = 1'b1;
                end
            end
            DONE: begin
                if (cs_high) begin
                    state_d   = IDLE;
                    err_pulse = !to_q && (cmd_q != CMD_WR) && (cmd_q != CMD_RD);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            to_q       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            miso_shift <= '0;
            miso       <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q   <= state_d;
            wr_en     <= do_wr;
            rd_req    <= do_rd;
            frame_err <= err_pulse;
            if (state_q == IDLE) begin
                bit_cnt <= '0;
                to_q    <= 1'b0;
            end else begin
                if (do_shift) bit_cnt <= bit_cnt + 6'd1;
                if (set_to)   to_q    <= 1'b1;
            end
            if (do_shift) shift_q <= {shift_q[30:0], mosi_s2};
            if (ld_cmd)   cmd_q   <= {shift_q[6:0], mosi_s2};
            if (ld_addr)  addr_q  <= {shift_q[14:0], mosi_s2};
            if (do_rd)    rd_addr <= {shift_q[14:0], mosi_s2};
            if (do_wr) begin
                wr_addr <= addr_q;
                wr_data <= {shift_q[30:0], mosi_s2};
            end
            // Register file answers one cycle after rd_req; first DATA fall then shows bit 31.
            if (rd_req)
                miso_shift <= rd_data;
            else if (state_q == DATA && sclk_fall && cmd_q == CMD_RD)
                miso_shift <= {miso_shift[30:0], 1'b0};
            if (state_q != DATA)
                miso <= 1'b0;
            else if (sclk_fall && cmd_q == CMD_RD)
                miso <= miso_shift[31];
            if (err_pulse && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rcb_spi_slave.sv
// Self-checking bench for rcb_spi_slave: bit-banged SPI master, register-file read model,
// write/read scoreboards fed from the stimulus side.
module tb_rcb_spi_slave;

`ifdef RCB_SPI_TIMEOUT_EN
  localparam logic [15:0] TO_CYC = 16'd100;
`else
  localparam logic [15:0] TO_CYC = 16'd2000;
`endif

  logic        clk_100m = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = 32'h0;
  logic        busy;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int fe_seen = 0;
  logic [47:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [55:0] rx_all;

  rcb_spi_slave #(.CMD_WR(8'h01), .CMD_RD(8'h02), .TIMEOUT(TO_CYC)) dut (
    .clk_100m(clk_100m), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .frame_err(frame_err), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_100m = ~clk_100m;

  function automatic logic [31:0] reg_model(input logic [15:0] a);
    reg_model = (a == 16'h0020) ? 32'h12345678 : {a ^ 16'hA5A5, a};
  endfunction

  // Register file: data is valid only in the cycle after rd_req.
  always @(negedge clk_100m)
    rd_data = rd_req ? reg_model(rd_addr) : 32'hBAD0_BAD0;

  // scoreboard
  always @(negedge clk_100m) begin
    if (frame_err) fe_seen++;
    if (wr_en) begin
      vectors++;
      if (exp_wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_wr_en: addr=%h data=%h, required no strobe", wr_addr, wr_data);
      end else begin
        logic [47:0] e;
        e = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          miscompares++;
          $display("FAIL wr_strobe: got %h, required %h", {wr_addr, wr_data}, e);
        end
      end
    end
    if (rd_req) begin
      vectors++;
      if (exp_rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rd_req: addr=%h, required no request", rd_addr);
      end else begin
        logic [15:0] e;
        e = exp_rd_q.pop_front();
        if (rd_addr !== e) begin
          miscompares++;
          $display("FAIL rd_addr: got %h, required %h", rd_addr, e);
        end
      end
    end
  end

  // driver tasks
  task automatic spi_start();
    @(posedge clk_100m);
    #3;
    rx_all = '0;
    cs_n = 1'b0;
    #50;
  endtask

  task automatic spi_bits(input logic [55:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = val[55-i];
      #50;
      rx_all = {rx_all[54:0], miso};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end(input int gap);
    #50;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(gap);
  endtask

  task automatic check_q_empty(input string name);
    vectors++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: pending wr=%0d rd=%0d, required 0/0", name, exp_wr_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({miso, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err, err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL %s: miso=%b wr_en=%b wr_addr=%h wr_data=%h rd_req=%b rd_addr=%h busy=%b frame_err=%b err_cnt=%h, required all 0",
               name, miso, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err, err_cnt);
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (4) @(posedge clk_100m);
    @(negedge clk_100m);
    check_idle_outputs("reset_outputs_in_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk_100m);
    check_idle_outputs("reset_outputs_after_release");
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    exp_wr_q.push_back({a, d});
    spi_start();
    spi_bits({8'h01, a, d}, 56);
    spi_end(200);
  endtask

  task automatic test_write();
    int fe0 = fe_seen;
    do_write(16'h0010, 32'hDEADBEEF);
    check_q_empty("write_seen");
    check_val("write_err_cnt", {24'h0, err_cnt}, 32'h0);
    check_val("write_busy_after", {31'h0, busy}, 32'h0);
    for (int k = 0; k < 4; k++)
      do_write(16'($urandom_range(0, 16'hFFFF)), $urandom());
    check_q_empty("write_random_seen");
    check_val("write_no_frame_err", fe_seen - fe0, 0);
  endtask

  task automatic do_read(input logic [15:0] a);
    exp_rd_q.push_back(a);
    spi_start();
    spi_bits({8'h02, a, 32'h0}, 56);
    spi_end(200);
    check_val("read_miso_data", rx_all[31:0], reg_model(a));
    check_val("read_miso_low_hdr", {8'h0, rx_all[55:32]}, 32'h0);
  endtask

  task automatic test_read();
    do_read(16'h0020);
    do_read(16'($urandom_range(0, 16'hFFFF)));
    do_read(16'hFFFF);
    check_q_empty("read_seen");
  endtask

  task automatic test_abort();
    int fe0 = fe_seen;
    spi_start();
    spi_bits({8'h01, 16'h0040, 32'hCAFEF00D}, 30);
    spi_end(200);
    check_val("abort_frame_err_count", fe_seen - fe0, 1);
    check_val("abort_err_cnt", {24'h0, err_cnt}, 32'h1);
    check_q_empty("abort_no_strobe");
  endtask

  task automatic test_unknown_cmd();
    int fe0 = fe_seen;
    spi_start();
    spi_bits({8'h7F, 16'h0010, 32'h11223344}, 56);
    #200;
    check_val("unknown_no_err_before_cs", fe_seen - fe0, 0);
    check_val("unknown_busy_in_done", {31'h0, busy}, 32'h1);
    spi_end(200);
    check_val("unknown_err_at_cs_rise", fe_seen - fe0, 1);
    check_q_empty("unknown_no_strobe");
  endtask

  task automatic test_cs_same_edge();
    int fe0 = fe_seen;
    logic [55:0] f;
    f = {8'h01, 16'h1234, 32'h0BADF00D};
    exp_wr_q.push_back({16'h1234, 32'h0BADF00D});
    spi_start();
    spi_bits(f, 55);
    mosi = f[0];
    #50;
    sclk = 1'b1;
    cs_n = 1'b1;
    #50;
    sclk = 1'b0;
    #200;
    check_q_empty("cs_same_edge_write");
    check_val("cs_same_edge_no_err", fe_seen - fe0, 0);
    check_val("cs_same_edge_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic test_extra_clocks();
    int fe0 = fe_seen;
    exp_wr_q.push_back({16'h00AA, 32'h55AA55AA});
    spi_start();
    spi_bits({8'h01, 16'h00AA, 32'h55AA55AA}, 56);
    spi_bits({56{1'b1}}, 3);
    spi_end(200);
    check_q_empty("extra_clocks_single_write");
    check_val("extra_clocks_no_err", fe_seen - fe0, 0);
  endtask

  task automatic test_back_to_back();
    exp_wr_q.push_back({16'h0100, 32'hA5A5A5A5});
    spi_start();
    spi_bits({8'h01, 16'h0100, 32'hA5A5A5A5}, 56);
    spi_end(100);
    exp_rd_q.push_back(16'h0101);
    spi_start();
    spi_bits({8'h02, 16'h0101, 32'h0}, 56);
    spi_end(100);
    check_val("b2b_read_data", rx_all[31:0], reg_model(16'h0101));
    check_q_empty("b2b_all_seen");
  endtask

`ifdef RCB_SPI_TIMEOUT_EN
  task automatic test_timeout();
    int fe0 = fe_seen;
    int c;
    spi_start();
    spi_bits({8'h01, 16'h0200, 32'h01020304}, 40);
    c = 0;
    while (fe_seen == fe0 && c < 300) begin
      @(posedge clk_100m);
      c++;
    end
    vectors++;
    if (c < 98 || c > 110) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles, required 98..110", c);
    end
    spi_end(200);
    check_val("timeout_single_err", fe_seen - fe0, 1);
    check_q_empty("timeout_no_strobe");
  endtask
`endif

  task automatic test_saturate();
    int fe0 = fe_seen;
    for (int k = 0; k < 256; k++) begin
      spi_start();
      spi_bits(56'($urandom()), 4);
      spi_end(100);
    end
    check_val("saturate_err_pulses", fe_seen - fe0, 256);
    check_val("saturate_err_cnt", {24'h0, err_cnt}, 32'hFF);
  endtask

  task automatic test_reset_mid();
    int fe0 = fe_seen;
    spi_start();
    spi_bits({8'h01, 16'h0300, 32'h0}, 12);
    check_val("reset_mid_busy_before", {31'h0, busy}, 32'h1);
    @(negedge clk_100m);
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_outputs");
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    rst = 1'b0;
    repeat (5) @(negedge clk_100m);
    check_val("reset_mid_no_frame_err", fe_seen - fe0, 0);
    do_write(16'h0010, 32'hFEEDFACE);
    check_q_empty("reset_mid_good_write");
    check_val("reset_mid_err_cnt", {24'h0, err_cnt}, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_unknown_cmd();
    test_cs_same_edge();
    test_extra_clocks();
    test_back_to_back();
`ifdef RCB_SPI_TIMEOUT_EN
    test_timeout();
`endif
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
